// File: rtl/divider_scheduler.sv
// divider_scheduler
//   Round-robin front end that shares one external divider among NUM_REQ
//   requesters. A job (dividend, divisor) is accepted over valid/ready, the
//   divider is driven through clear -> load entry_1 -> load entry_2 -> run,
//   and the quotient comes back tagged with the requester ID.
//   Divide-by-zero is answered locally (16'hFFFF, div0 flag) and a divider
//   that never raises show_result is aborted after TIMEOUT run cycles
//   (16'h0000, timeout flag).
// Ports
//   clk, reset                         clock, async active-high reset
//   req_valid/req_ready                per-requester job handshake
//   req_dividend/req_divisor           packed operands, 16 bits per requester
//   resp_valid/resp_ready              response handshake
//   resp_id/resp_quotient              served requester and its quotient
//   resp_div0/resp_timeout             local error flags
//   busy                               high whenever not IDLE
//   div_reset/div_divide/div_show      divider control
//   div_entry_1/div_entry_2            divider operands
//   div_result/div_show_result         divider quotient and done flag
module divider_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 31
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*16-1:0]   req_dividend,
  input  logic [NUM_REQ*16-1:0]   req_divisor,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [15:0]             resp_quotient,
  output logic                    resp_div0,
  output logic                    resp_timeout,
  output logic                    busy,
  output logic                    div_reset,
  output logic                    div_divide,
  output logic                    div_show,
  output logic [15:0]             div_entry_1,
  output logic [15:0]             div_entry_2,
  input  logic [15:0]             div_result,
  input  logic                    div_show_result
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_DZ, S_CLR, S_LOAD_A, S_LOAD_B, S_RUN, S_RESP
  } state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_rr;
  logic [ID_W-1:0]   r_id;
  logic [15:0]       r_dvd;
  logic [15:0]       r_dvs;
  logic [7:0]        r_cnt;

  logic              w_pick_vld;
  logic [ID_W-1:0]   w_pick_id;
  logic [15:0]       w_dvd;
  logic [15:0]       w_dvs;

  // First valid requester after rr, wrapping. Scanning from the farthest
  // offset down lets the nearest one overwrite the result.
  function automatic logic [ID_W:0] f_pick(input logic [NUM_REQ-1:0] v,
                                           input logic [ID_W-1:0]    rr);
    logic [ID_W:0]   r;
    logic [ID_W-1:0] idx;
    r = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(rr) + k) % NUM_REQ);
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign {w_pick_vld, w_pick_id} = f_pick(req_valid, r_rr);

  // Operand mux for the granted requester; {id,4'b0} is id*16.
  assign w_dvd = req_dividend[{r_id, 4'b0000} +: 16];
  assign w_dvs = req_divisor[{r_id, 4'b0000} +: 16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rr          <= ID_W'(NUM_REQ - 1);
      r_id          <= '0;
      r_dvd         <= '0;
      r_dvs         <= '0;
      r_cnt         <= '0;
      req_ready     <= '0;
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      resp_quotient <= '0;
      resp_div0     <= 1'b0;
      resp_timeout  <= 1'b0;
      busy          <= 1'b0;
      div_reset     <= 1'b1;
      div_divide    <= 1'b0;
      div_show      <= 1'b0;
      div_entry_1   <= '0;
      div_entry_2   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          div_reset <= 1'b0;
          if (w_pick_vld) begin
            req_ready <= NUM_REQ'(1) << w_pick_id;
            r_id      <= w_pick_id;
            busy      <= 1'b1;
            r_state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          req_ready <= '0;
          r_rr      <= r_id;
          r_dvd     <= w_dvd;
          r_dvs     <= w_dvs;
          if (w_dvs == 16'h0000) begin
            r_state <= S_DZ;
          end else begin
            div_reset  <= 1'b1;
            div_divide <= 1'b0;
            div_show   <= 1'b0;
            r_state    <= S_CLR;
          end
        end
        // Divide-by-zero: the divider is never touched; this cycle only
        // builds the response from the captured job.
        S_DZ: begin
          resp_valid    <= 1'b1;
          resp_id       <= r_id;
          resp_quotient <= 16'hFFFF;
          resp_div0     <= 1'b1;
          resp_timeout  <= 1'b0;
          r_state       <= S_RESP;
        end
        S_CLR: begin
          div_reset   <= 1'b0;
          div_divide  <= 1'b1;
          div_entry_1 <= r_dvd;
          r_state     <= S_LOAD_A;
        end
        S_LOAD_A: begin
          div_divide  <= 1'b0;
          div_entry_2 <= r_dvs;
          r_state     <= S_LOAD_B;
        end
        S_LOAD_B: begin
          div_show <= 1'b1;
          r_cnt    <= '0;
          r_state  <= S_RUN;
        end
        // show_result is tested first so it wins over a same-cycle timeout.
        S_RUN: begin
          if (div_show_result) begin
            div_show      <= 1'b0;
            resp_valid    <= 1'b1;
            resp_id       <= r_id;
            resp_quotient <= div_result;
            resp_div0     <= 1'b0;
            resp_timeout  <= 1'b0;
            r_state       <= S_RESP;
          end else if (r_cnt == 8'(TIMEOUT - 1)) begin
            div_show      <= 1'b0;
            resp_valid    <= 1'b1;
            resp_id       <= r_id;
            resp_quotient <= 16'h0000;
            resp_div0     <= 1'b0;
            resp_timeout  <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_scheduler.sv
module tb_divider_scheduler;
  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int TO  = 31;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR*16-1:0]     req_dividend;
  logic [NR*16-1:0]     req_divisor;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [IDW-1:0]       resp_id;
  logic [15:0]          resp_quotient;
  logic                 resp_div0;
  logic                 resp_timeout;
  logic                 busy;
  logic                 div_reset;
  logic                 div_divide;
  logic                 div_show;
  logic [15:0]          div_entry_1;
  logic [15:0]          div_entry_2;
  logic [15:0]          div_result;
  logic                 div_show_result;

  divider_scheduler #(.NUM_REQ(NR), .ID_W(IDW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_quotient(resp_quotient),
    .resp_div0(resp_div0), .resp_timeout(resp_timeout),
    .busy(busy),
    .div_reset(div_reset), .div_divide(div_divide), .div_show(div_show),
    .div_entry_1(div_entry_1), .div_entry_2(div_entry_2),
    .div_result(div_result), .div_show_result(div_show_result)
  );

  always #5 clk = ~clk;

  // Divider model: done 16 cycles after show rises (17 RUN cycles total);
  // 'hang' models a divider that never finishes.
  logic hang;
  int   dcnt;
  always @(posedge clk) begin
    if (div_reset || !div_show) dcnt <= 0;
    else                        dcnt <= dcnt + 1;
  end
  assign div_show_result = !hang && div_show && (dcnt >= 16);
  assign div_result      = (div_entry_2 == 16'h0) ? 16'hFFFF : div_entry_1 / div_entry_2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    q;
    logic           d0;
    logic           to;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   checks = 0;
  int   errors = 0;
  bit   saw_divide, saw_show, saw_clr;
  exp_t mon_e;

  // Scoreboard: compare every completed response transfer.
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got id=%0d q=%h div0=%0d to=%0d",
                 resp_id, resp_quotient, resp_div0, resp_timeout);
      end else begin
        mon_e = sb.pop_front();
        if ({resp_id, resp_quotient, resp_div0, resp_timeout} !== mon_e) begin
          errors++;
          $display("FAIL resp got id=%0d q=%h div0=%0d to=%0d exp id=%0d q=%h div0=%0d to=%0d",
                   resp_id, resp_quotient, resp_div0, resp_timeout,
                   mon_e.id, mon_e.q, mon_e.d0, mon_e.to);
        end
      end
    end
  end

  // One clock; requesters drop valid as soon as they see ready.
  task automatic step();
    @(posedge clk); #1;
    saw_divide |= div_divide;
    saw_show   |= div_show;
    saw_clr    |= div_reset;
    for (int i = 0; i < NR; i++)
      if (req_ready[i]) begin
        req_valid[i] = 1'b0;
        grants.push_back(i);
      end
  endtask

  task automatic post(input int i, input logic [15:0] a, input logic [15:0] b, input bit hung);
    exp_t e;
    req_dividend[16*i +: 16] = a;
    req_divisor[16*i +: 16]  = b;
    req_valid[i]             = 1'b1;
    e.id = IDW'(i);
    e.d0 = (b == 16'h0);
    e.to = hung && (b != 16'h0);
    e.q  = e.d0 ? 16'hFFFF : (hung ? 16'h0000 : a / b);
    sb.push_back(e);
  endtask

  task automatic wait_resp(output int n, input int budget);
    n = 0;
    while (!resp_valid && n < budget) begin
      step();
      n++;
    end
    if (!resp_valid) begin
      errors++;
      $display("FAIL wait_resp no resp_valid within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || resp_valid || sb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (busy || resp_valid || sb.size() != 0) begin
      errors++;
      $display("FAIL wait_idle busy=%0d resp_valid=%0d pending=%0d exp 0 0 0",
               busy, resp_valid, sb.size());
    end
  endtask

  function automatic logic [60:0] outs();
    return {req_ready, resp_valid, resp_id, resp_quotient, resp_div0, resp_timeout,
            busy, div_reset, div_divide, div_show, div_entry_1, div_entry_2};
  endfunction

  localparam logic [60:0] RST_VEC = {4'b0, 1'b0, 2'b0, 16'h0, 3'b0, 1'b1, 2'b0, 32'h0};

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++;
    if (outs() !== RST_VEC) begin
      errors++;
      $display("FAIL reset_values got %h exp %h", outs(), RST_VEC);
    end
    reset = 1'b0;
    step();
    checks++;
    if (div_reset !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got div_reset=%0d busy=%0d exp 0 0", div_reset, busy);
    end
  endtask

  task automatic test_single();
    int n;
    grants.delete();
    post(0, 16'd100, 16'd7, 1'b0);
    wait_resp(n, 60);
    checks++;
    if (n != 22) begin
      errors++;
      $display("FAIL single_latency got %0d exp 22", n);
    end
    wait_idle(20);
    checks++;
    if (grants.size() != 1 || grants[0] != 0) begin
      errors++;
      $display("FAIL single_ready_pulse got %0d pulses first=%0d exp 1 pulse on 0",
               grants.size(), (grants.size() > 0) ? grants[0] : -1);
    end
  endtask

  task automatic test_round_robin();
    int exp_ord[4] = '{0, 1, 2, 3};
    bit bad;
    test_reset();
    grants.delete();
    post(1, 16'd500, 16'd20, 1'b0);
    post(3, 16'd65535, 16'd1, 1'b0);
    wait_idle(200);
    checks++;
    if (grants.size() != 2 || grants[0] != 1 || grants[1] != 3) begin
      errors++;
      $display("FAIL rr_pair got size=%0d first=%0d exp order 1,3",
               grants.size(), (grants.size() > 0) ? grants[0] : -1);
    end
    grants.delete();
    for (int i = 0; i < NR; i++)
      post(i, 16'(1000 * i + 77), 16'(i + 3), 1'b0);
    wait_idle(400);
    bad = (grants.size() != 4);
    for (int i = 0; i < 4 && !bad; i++) if (grants[i] != exp_ord[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rr_all got size=%0d first=%0d exp order 0,1,2,3",
               grants.size(), (grants.size() > 0) ? grants[0] : -1);
    end
  endtask

  task automatic test_div0();
    int n;
    saw_divide = 1'b0;
    saw_show   = 1'b0;
    post(2, 16'd9, 16'd0, 1'b0);
    wait_resp(n, 20);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL div0_latency got %0d exp 3", n);
    end
    wait_idle(20);
    checks++;
    if (saw_divide || saw_show) begin
      errors++;
      $display("FAIL div0_untouched got divide=%0d show=%0d exp 0 0", saw_divide, saw_show);
    end
  endtask

  task automatic test_timeout();
    int n;
    hang = 1'b1;
    post(1, 16'd1234, 16'd3, 1'b1);
    wait_resp(n, 100);
    checks++;
    if (n != 5 + TO) begin
      errors++;
      $display("FAIL timeout_latency got %0d exp %0d", n, 5 + TO);
    end
    wait_idle(20);
    hang    = 1'b0;
    saw_clr = 1'b0;
    post(2, 16'd1000, 16'd10, 1'b0);
    wait_resp(n, 60);
    checks++;
    if (n != 22 || !saw_clr) begin
      errors++;
      $display("FAIL after_timeout got latency=%0d clr=%0d exp 22 1", n, saw_clr);
    end
    wait_idle(20);
  endtask

  task automatic test_backpressure();
    int n;
    bit stable = 1'b1;
    resp_ready = 1'b0;
    post(0, 16'd40, 16'd5, 1'b0);
    wait_resp(n, 60);
    grants.delete();
    post(3, 16'd30, 16'd6, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (resp_valid !== 1'b1 || resp_quotient !== 16'd8 || resp_id !== 2'd0) stable = 1'b0;
    end
    checks++;
    if (!stable || grants.size() != 0) begin
      errors++;
      $display("FAIL bp_hold got stable=%0d grants=%0d exp 1 0", stable, grants.size());
    end
    resp_ready = 1'b1;
    step();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got resp_valid=%0d exp 0", resp_valid);
    end
    wait_idle(60);
    checks++;
    if (grants.size() != 1 || grants[0] != 3) begin
      errors++;
      $display("FAIL bp_next_grant got size=%0d exp one grant on 3", grants.size());
    end
  endtask

  task automatic test_reset_run();
    int n = 0;
    bit spurious = 1'b0;
    post(1, 16'd500, 16'd3, 1'b0);
    while (!div_show && n < 30) begin step(); n++; end
    repeat (5) step();
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== RST_VEC) begin
      errors++;
      $display("FAIL reset_in_run got %h exp %h", outs(), RST_VEC);
    end
    sb.delete();
    req_valid = '0;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (resp_valid) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL reset_abort got resp_valid=1 exp 0");
    end
    post(0, 16'd77, 16'd11, 1'b0);
    wait_resp(n, 60);
    checks++;
    if (n != 22) begin
      errors++;
      $display("FAIL post_reset_latency got %0d exp 22", n);
    end
    wait_idle(20);
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    resp_ready   = 1'b1;
    hang         = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_div0();
    test_timeout();
    test_backpressure();
    test_reset_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/divider_scheduler.md
Name: divider_scheduler

Overview:
- Round-robin scheduler that shares one divider_module instance among NUM_REQ requesting KPN processes.
- Accepts (dividend, divisor) jobs over valid/ready, then sequences the divider's load/compute protocol: clear, latch entry_1, latch entry_2, run until show_result.
- Returns the quotient with the requester ID over a valid/ready response channel.
- Divide-by-zero and a hung divider are handled locally.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ID_W, 2: requester ID width; must equal clog2(NUM_REQ).
- TIMEOUT, 31: maximum RUN cycles to wait for div_show_result before aborting (1..255).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester job valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_dividend  in  NUM_REQ*16  packed dividends; requester i uses bits [16i+15:16i].
- req_divisor  in  NUM_REQ*16  packed divisors, same packing.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  index of the requester served.
- resp_quotient  out  16  quotient.
- resp_div0  out  1  divisor was zero; quotient forced to 16'hFFFF.
- resp_timeout  out  1  divider did not finish within TIMEOUT; quotient forced to 16'h0000.
- busy  out  1  high in every state except IDLE.
- div_reset  out  1  synchronous clear to the divider.
- div_divide  out  1  divider "divide" input.
- div_show  out  1  divider "show_division" input.
- div_entry_1  out  16  divider dividend input.
- div_entry_2  out  16  divider divisor input.
- div_result  in  16  divider quotient.
- div_show_result  in  1  divider done flag.

Behaviour:
- All outputs are registered.
- Reset values:
  - State IDLE, rr pointer = NUM_REQ-1 (requester 0 has first priority), counters 0.
  - req_ready = 0, resp_valid = 0, resp_id = 0, resp_quotient = 0, resp_div0 = 0, resp_timeout = 0, busy = 0.
  - div_reset = 1, div_divide = 0, div_show = 0, div_entry_1 = 0, div_entry_2 = 0.
- Reset asserted in any state (including mid-RUN or mid-RESP) aborts the job with no response.
- FSM states:
  - IDLE: div_reset = 0. If any req_valid is set, grant the first valid index searching from rr+1 with wrap-around. In the same cycle, raise req_ready for the winner only and go to GRANT.
  - GRANT (1 cycle): the handshake completes here. Capture the winner's operands and ID, and set rr = winner. If divisor == 0, go to RESP with div0 = 1 and quotient 16'hFFFF; the divider stays untouched. Otherwise go to CLR.
  - CLR (1 cycle): div_reset = 1, div_divide = 0, div_show = 0.
  - LOAD_A (1 cycle): div_reset = 0, div_divide = 1, div_entry_1 = dividend.
  - LOAD_B (1 cycle): div_divide = 0, div_entry_2 = divisor. div_entry_1 is held.
  - RUN: div_show = 1 and the cycle counter increments each cycle.
    - div_show_result = 1: capture div_result, go to RESP.
    - Counter reaches TIMEOUT first: timeout = 1, quotient 0, go to RESP.
    - If both happen in the same cycle, div_show_result wins.
  - RESP: div_show = 0, resp_valid = 1. All response fields stay stable until resp_valid & resp_ready, then go to IDLE. During the transfer cycle, resp_valid drops on the next edge.
- Requester rules:
  - A requester holds req_valid and its operands until it sees req_ready.
  - req_ready is high for exactly one cycle per job.
  - Deasserting req_valid before grant is legal; that requester is then skipped.
- Job pipeline: one job in flight; no new grant until RESP completes. The next grant is evaluated in the IDLE cycle that follows RESP.
- Latency, normal job (req_valid to resp_valid): IDLE 1 + GRANT 1 + CLR 1 + LOAD_A 1 + LOAD_B 1 + RUN (17 with the standard divider) = 22 cycles.
- Latency, div0 job: 3 cycles.
- Fairness: with all requesters valid continuously, grants rotate 0,1,2,3,0,…
- Arithmetic: unsigned 16-bit. The quotient is passed through unchanged; remainder is not reported.

Test Plan:
- Req0 sends 100/7 alone -> req_ready[0] pulses once; resp_valid 22 cycles after req_valid; resp_id = 0, quotient = 14, div0 = 0, timeout = 0.
- Req1 (500/20) and req3 (65535/1) valid in the same cycle after reset -> req1 served first (quotient 25), then req3 (quotient 65535). Next, req0–3 all valid -> grant order 0,1,2,3.
- Req2 sends 9/0 -> resp after 3 cycles with id = 2, quotient = 16'hFFFF, div0 = 1; div_divide and div_show never assert.
- Stub divider holds div_show_result = 0 -> after TIMEOUT = 31 RUN cycles, resp_timeout = 1 and quotient = 0. Next job proceeds through CLR normally.
- Hold resp_ready = 0 for 10 cycles on a 40/5 job -> resp_valid stays 1 with quotient = 8 stable; no req_ready while pending; completes on the first resp_ready = 1.
- Assert reset during RUN -> all outputs at reset values immediately (div_reset = 1), no response issued. After release, a 77/11 job returns 7.
